// File: rtl/bcd_time_counter.sv
// bcd_time_counter
//   Cascaded multi-digit counter with a programmable modulus per digit,
//   driven by a prescaled step. The default configuration is an MM:SS
//   timer (digit bases {6,10,6,10}, digit 0 = least significant).
//
// Ports
//   clk         in   single clock, all state updates on the rising edge
//   rst         in   asynchronous assert, active-low; release is synchronised
//   start       in   one-cycle request to run (IDLE/PAUSE/DONE)
//   stop        in   one-cycle request to pause (RUN)
//   clear       in   synchronous clear to zero and IDLE
//   load        in   synchronous load of load_value (ignored in RUN)
//   load_value  in   preset value, same digit layout as number
//   up_down     in   1 = count up, 0 = count down
//   number      out  registered count value
//   tick        out  one-cycle pulse with every stepped value on number
//   terminal    out  one-cycle pulse on reaching / wrapping past terminal
//   state       out  IDLE=0, RUN=1, PAUSE=2, DONE=3
module bcd_time_counter #(
  parameter int unsigned                           NUM_DIGITS     = 4,
  parameter int unsigned                           BITS_PER_DIGIT = 4,
  parameter logic [NUM_DIGITS*BITS_PER_DIGIT-1:0]  DIGIT_BASES    = 16'h6A6A,
  parameter int unsigned                           TICK_DIVISOR   = 100_000_000,
  parameter int unsigned                           WRAP_MODE      = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   stop,
  input  logic                                   clear,
  input  logic                                   load,
  input  logic [NUM_DIGITS*BITS_PER_DIGIT-1:0]   load_value,
  input  logic                                   up_down,
  output logic [NUM_DIGITS*BITS_PER_DIGIT-1:0]   number,
  output logic                                   tick,
  output logic                                   terminal,
  output logic [1:0]                             state
);

  localparam int unsigned B  = BITS_PER_DIGIT;
  localparam int unsigned W  = NUM_DIGITS * BITS_PER_DIGIT;
  localparam int unsigned PW = (TICK_DIVISOR > 1) ? $clog2(TICK_DIVISOR) : 1;

  localparam logic [PW-1:0] PRE_MAX      = PW'(TICK_DIVISOR - 1);
  localparam logic [PW-1:0] PRE_ONE      = PW'(1);
  localparam logic [B-1:0]  DIG_ONE      = B'(1);
  localparam logic          STOP_AT_TERM = (WRAP_MODE == 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    num_q,   num_d;
  logic [PW-1:0]   pre_q,   pre_d;
  logic            tick_q,  tick_d;
  logic            term_q,  term_d;

  logic            rst_meta_q;
  logic            rst_sync_q;

  logic [W-1:0]    step_val;
  logic            cur_term;
  logic            next_term;

  // ---------------------------------------------------------------------
  // Digit helpers
  // ---------------------------------------------------------------------
  function automatic logic [B-1:0] base_of(input int unsigned idx);
    return DIGIT_BASES[idx*B +: B];
  endfunction

  // Any digit at or above its modulus is pulled down to base-1.
  function automatic logic [W-1:0] clamp_value(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [B-1:0] d;
    logic [B-1:0] b;
    r = v;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      d = v[i*B +: B];
      b = base_of(i);
      if (d >= b) begin
        r[i*B +: B] = b - DIG_ONE;
      end
    end
    return r;
  endfunction

  // Terminal value: every digit at base-1 (up) or every digit zero (down).
  function automatic logic is_terminal(input logic [W-1:0] v, input logic up);
    logic         t;
    logic [B-1:0] d;
    logic [B-1:0] b;
    t = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      d = v[i*B +: B];
      b = base_of(i);
      if (up) begin
        if (d != b - DIG_ONE) begin
          t = 1'b0;
        end
      end else begin
        if (d != '0) begin
          t = 1'b0;
        end
      end
    end
    return t;
  endfunction

  // One step with the full carry/borrow chain resolved combinationally;
  // a digit moves only while every lower digit sits at its boundary.
  function automatic logic [W-1:0] step_value(input logic [W-1:0] v, input logic up);
    logic [W-1:0] r;
    logic [B-1:0] d;
    logic [B-1:0] b;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      d = v[i*B +: B];
      b = base_of(i);
      if (carry) begin
        if (up) begin
          if (d == b - DIG_ONE) begin
            r[i*B +: B] = '0;
          end else begin
            r[i*B +: B] = d + DIG_ONE;
            carry       = 1'b0;
          end
        end else begin
          if (d == '0) begin
            r[i*B +: B] = b - DIG_ONE;
          end else begin
            r[i*B +: B] = d - DIG_ONE;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Reset release synchroniser: assertion is immediate, release is seen by
  // the counter logic two edges after rst rises.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath decode
  // ---------------------------------------------------------------------
  always_comb begin
    step_val  = step_value(num_q, up_down);
    cur_term  = is_terminal(num_q, up_down);
    next_term = is_terminal(step_val, up_down);
  end

  // ---------------------------------------------------------------------
  // Next-state / output logic. Priority: clear > load > stop > start > step.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    term_d  = 1'b0;

    if (!rst_sync_q) begin
      // Still inside the synchronised release window: hold reset values.
      state_d = ST_IDLE;
      num_d   = '0;
      pre_d   = '0;
    end else if (clear) begin
      state_d = ST_IDLE;
      num_d   = '0;
      pre_d   = '0;
    end else if (load && (state_q != ST_RUN)) begin
      state_d = ST_PAUSE;
      num_d   = clamp_value(load_value);
      pre_d   = '0;
    end else if (stop) begin
      // stop also swallows a coincident start; the prescaler holds.
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSE;
      end
    end else if (start && (state_q != ST_RUN)) begin
      if (STOP_AT_TERM && cur_term) begin
        state_d = ST_DONE;
        pre_d   = '0;
      end else begin
        state_d = ST_RUN;
      end
    end else if (state_q == ST_RUN) begin
      if (pre_q == PRE_MAX) begin
        pre_d  = '0;
        num_d  = step_val;
        tick_d = 1'b1;
        if (STOP_AT_TERM) begin
          if (next_term) begin
            term_d  = 1'b1;
            state_d = ST_DONE;
          end
        end else if (cur_term) begin
          term_d = 1'b1;
        end
      end else begin
        pre_d = pre_q + PRE_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      term_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      term_q  <= term_d;
    end
  end

  assign number   = num_q;
  assign tick     = tick_q;
  assign terminal = term_q;
  assign state    = state_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Testbench for bcd_time_counter: two instances (stop-at-terminal and wrap)
// share one stimulus stream; expected outputs are queued with the cycle at
// which they must appear and compared on the falling edge.
module tb_bcd_time_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, clear, load, up_down;
  logic [15:0] load_value;

  logic [15:0] num0, num1;
  logic        tick0, tick1, term0, term1;
  logic [1:0]  st0, st1;

  always #5 clk = ~clk;

  bcd_time_counter #(
    .NUM_DIGITS(4), .BITS_PER_DIGIT(4), .DIGIT_BASES(16'h6A6A),
    .TICK_DIVISOR(4), .WRAP_MODE(0)
  ) u_stop (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_value(load_value), .up_down(up_down),
    .number(num0), .tick(tick0), .terminal(term0), .state(st0)
  );

  bcd_time_counter #(
    .NUM_DIGITS(4), .BITS_PER_DIGIT(4), .DIGIT_BASES(16'h6A6A),
    .TICK_DIVISOR(4), .WRAP_MODE(1)
  ) u_wrap (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_value(load_value), .up_down(up_down),
    .number(num1), .tick(tick1), .terminal(term1), .state(st1)
  );

  typedef struct {
    string       tag;
    int unsigned cyc;
    int unsigned dut;
    logic [15:0] num;
    logic        tk;
    logic        tm;
    logic [1:0]  st;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int unsigned t0  = 0;
  int          checks   = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    string pfx;
    pfx = (e.dut == 0) ? "stop." : "wrap.";
    check({pfx, e.tag, ".number"},   (e.dut == 0) ? {16'h0, num0}  : {16'h0, num1},  {16'h0, e.num});
    check({pfx, e.tag, ".tick"},     (e.dut == 0) ? {31'h0, tick0} : {31'h0, tick1}, {31'h0, e.tk});
    check({pfx, e.tag, ".terminal"}, (e.dut == 0) ? {31'h0, term0} : {31'h0, term1}, {31'h0, e.tm});
    check({pfx, e.tag, ".state"},    (e.dut == 0) ? {30'h0, st0}   : {30'h0, st1},   {30'h0, e.st});
  endtask

  // Insert keeping the queue ordered by due cycle.
  function automatic void sb_push(input int unsigned k, input int unsigned dut, input string tag,
                                  input logic [15:0] num, input logic tk, input logic tm,
                                  input logic [1:0] st);
    exp_t e;
    int   i;
    e.tag = tag; e.cyc = t0 + k; e.dut = dut;
    e.num = num; e.tk = tk; e.tm = tm; e.st = st;
    i = 0;
    while (i < sb_q.size() && sb_q[i].cyc <= e.cyc) i++;
    sb_q.insert(i, e);
  endfunction

  function automatic void sb_both(input int unsigned k, input string tag, input logic [15:0] num,
                                  input logic tk, input logic tm, input logic [1:0] st);
    sb_push(k, 0, tag, num, tk, tm, st);
    sb_push(k, 1, tag, num, tk, tm, st);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      check_outputs(e);
    end
  end

  // Called on a falling edge; the pulses are sampled by the next rising edge.
  task automatic drive(input logic st, input logic sp, input logic cl, input logic ld,
                       input logic [15:0] lv);
    start = st; stop = sp; clear = cl; load = ld; load_value = lv;
    t0 = cyc;
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    end
  endtask

  task automatic check_reset_now(input string tag);
    check({tag, ".stop.number"}, {16'h0, num0}, 32'h0);
    check({tag, ".stop.state"},  {30'h0, st0},  32'h0);
    check({tag, ".stop.tick"},   {31'h0, tick0}, 32'h0);
    check({tag, ".stop.term"},   {31'h0, term0}, 32'h0);
    check({tag, ".wrap.number"}, {16'h0, num1}, 32'h0);
    check({tag, ".wrap.state"},  {30'h0, st1},  32'h0);
    check({tag, ".wrap.tick"},   {31'h0, tick1}, 32'h0);
    check({tag, ".wrap.term"},   {31'h0, term1}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    up_down = 1'b1; load_value = 16'h0;
    #1 rst = 1'b0;
    #2 check_reset_now("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_cycles(3);

    // Load then count up across a two-digit carry.
    drive(0, 0, 0, 1, 16'h0959);
    sb_both(1, "load0959", 16'h0959, 0, 0, 2);
    wait_cycles(1);
    drive(1, 0, 0, 0, 16'h0);
    for (int k = 1; k <= 4; k++) sb_both(k, "hold0959", 16'h0959, 0, 0, 1);
    sb_both(5, "carry1000", 16'h1000, 1, 0, 1);
    sb_both(6, "after1000", 16'h1000, 0, 0, 1);
    wait_cycles(6);

    // Reach the up terminal: stop instance halts, wrap instance rolls over.
    drive(0, 0, 1, 0, 16'h0);
    sb_both(1, "clear1", 16'h0000, 0, 0, 0);
    wait_cycles(1);
    drive(0, 0, 0, 1, 16'h5958);
    sb_both(1, "load5958", 16'h5958, 0, 0, 2);
    wait_cycles(1);
    drive(1, 0, 0, 0, 16'h0);
    sb_both(4, "pre5958", 16'h5958, 0, 0, 1);
    sb_push(5, 0, "reach5959", 16'h5959, 1, 1, 3);
    sb_push(6, 0, "done5959", 16'h5959, 0, 0, 3);
    sb_push(10, 0, "frozen5959", 16'h5959, 0, 0, 3);
    sb_push(5, 1, "step5959", 16'h5959, 1, 0, 1);
    sb_push(9, 1, "wrapup", 16'h0000, 1, 1, 1);
    wait_cycles(10);
    drive(1, 0, 0, 0, 16'h0);
    sb_push(1, 0, "start_at_term", 16'h5959, 0, 0, 3);
    sb_push(1, 1, "start_in_run", 16'h0000, 0, 0, 1);
    wait_cycles(1);

    // Count down from zero.
    drive(0, 0, 1, 0, 16'h0);
    sb_both(1, "clear2", 16'h0000, 0, 0, 0);
    wait_cycles(1);
    up_down = 1'b0;
    drive(1, 0, 0, 0, 16'h0);
    sb_push(1, 0, "dn_start_term", 16'h0000, 0, 0, 3);
    sb_push(5, 0, "dn_done_hold", 16'h0000, 0, 0, 3);
    sb_push(1, 1, "dn_run", 16'h0000, 0, 0, 1);
    sb_push(4, 1, "dn_pre", 16'h0000, 0, 0, 1);
    sb_push(5, 1, "dn_wrap", 16'h5959, 1, 1, 1);
    wait_cycles(5);
    up_down = 1'b1;
    drive(1, 0, 0, 0, 16'h0);
    sb_push(1, 0, "done_restart", 16'h0000, 0, 0, 1);
    sb_push(4, 0, "restart_pre", 16'h0000, 0, 0, 1);
    sb_push(5, 0, "up_step", 16'h0001, 1, 0, 1);
    sb_push(1, 1, "wrap_run", 16'h5959, 0, 0, 1);
    sb_push(4, 1, "wrap_from_term", 16'h0000, 1, 1, 1);
    wait_cycles(5);
    // Direction change mid-run; prescaler phase must be preserved.
    up_down = 1'b0;
    drive(0, 0, 0, 0, 16'h0);
    sb_push(3, 0, "dir_pre", 16'h0001, 0, 0, 1);
    sb_push(4, 0, "dir_reach0", 16'h0000, 1, 1, 3);
    sb_push(2, 1, "dir_pre", 16'h0000, 0, 0, 1);
    sb_push(3, 1, "dir_wrap", 16'h5959, 1, 1, 1);
    wait_cycles(4);

    // Clamping, clear vs load priority, load ignored in RUN.
    drive(0, 0, 1, 0, 16'h0);
    sb_both(1, "clear3", 16'h0000, 0, 0, 0);
    wait_cycles(1);
    drive(0, 0, 0, 1, 16'h7FAB);
    sb_both(1, "clamp7FAB", 16'h5959, 0, 0, 2);
    wait_cycles(1);
    drive(0, 0, 1, 1, 16'h7FAB);
    sb_both(1, "clear_load", 16'h0000, 0, 0, 0);
    wait_cycles(1);
    drive(0, 0, 0, 1, 16'h3C4A);
    sb_both(1, "clamp3C4A", 16'h3949, 0, 0, 2);
    wait_cycles(1);
    drive(1, 0, 0, 0, 16'h0);
    sb_both(1, "run3949", 16'h3949, 0, 0, 1);
    wait_cycles(1);
    drive(0, 0, 0, 1, 16'h1234);
    sb_both(1, "load_in_run", 16'h3949, 0, 0, 1);
    sb_both(3, "load_no_pre", 16'h3949, 0, 0, 1);
    sb_both(4, "borrow3948", 16'h3948, 1, 0, 1);
    wait_cycles(4);

    // Pause holds the prescaler phase; start+stop resolves to stop.
    up_down = 1'b1;
    drive(0, 0, 1, 0, 16'h0);
    sb_both(1, "clear4", 16'h0000, 0, 0, 0);
    wait_cycles(1);
    drive(1, 0, 0, 0, 16'h0);
    sb_both(1, "p_run", 16'h0000, 0, 0, 1);
    wait_cycles(3);
    drive(0, 1, 0, 0, 16'h0);
    sb_both(1, "p_pause", 16'h0000, 0, 0, 2);
    sb_both(10, "p_idle", 16'h0000, 0, 0, 2);
    wait_cycles(11);
    drive(1, 0, 0, 0, 16'h0);
    sb_both(1, "p_restart", 16'h0000, 0, 0, 1);
    sb_both(2, "p_pre3", 16'h0000, 0, 0, 1);
    sb_both(3, "p_tick", 16'h0001, 1, 0, 1);
    wait_cycles(3);
    drive(1, 1, 0, 0, 16'h0);
    sb_both(1, "ss_run", 16'h0001, 0, 0, 2);
    wait_cycles(1);
    drive(1, 1, 0, 0, 16'h0);
    sb_both(1, "ss_pause", 16'h0001, 0, 0, 2);
    wait_cycles(1);

    // Asynchronous reset between edges while a tick is on the outputs.
    drive(1, 0, 0, 0, 16'h0);
    sb_both(5, "pre_reset_tick", 16'h0002, 1, 0, 1);
    wait_cycles(5);
    #2 rst = 1'b0;
    #1 check_reset_now("async_reset");
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(3);
    drive(1, 0, 0, 0, 16'h0);
    sb_both(1, "post_rst_run", 16'h0000, 0, 0, 1);
    sb_both(5, "post_rst_step", 16'h0001, 1, 0, 1);
    wait_cycles(6);

    for (int n = 0; n < 20 && sb_q.size() > 0; n++) @(negedge clk);
    if (sb_q.size() != 0) check("scoreboard_drain", sb_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_time_counter.md
BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of cascaded digits.
REQ-002 Parameter BITS_PER_DIGIT, default 4: width of each digit field.
REQ-003 Parameter DIGIT_BASES, NUM_DIGITS*BITS_PER_DIGIT bits, default {6,10,6,10}: modulus of digit i at field [i*BITS_PER_DIGIT +: BITS_PER_DIGIT], digit 0 = LSB, giving MM:SS by default.
REQ-004 Parameter TICK_DIVISOR, default 100_000_000: clk cycles per count step; legal range >= 1.
REQ-005 Parameter WRAP_MODE, default 0: 0 = stop at terminal value, 1 = wrap around.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset, asynchronous assert, active-low.
REQ-008 start  in  1  one-cycle request to run.
REQ-009 stop  in  1  one-cycle request to pause.
REQ-010 clear  in  1  synchronous clear to zero and IDLE.
REQ-011 load  in  1  synchronous load of load_value.
REQ-012 load_value  in  NUM_DIGITS*BITS_PER_DIGIT  preset value, same digit layout as number.
REQ-013 up_down  in  1  1 = count up, 0 = count down.
REQ-014 number  out  NUM_DIGITS*BITS_PER_DIGIT  registered count value.
REQ-015 tick  out  1  registered one-cycle pulse, coincident with each new stepped value on number.
REQ-016 terminal  out  1  registered one-cycle pulse on reaching (WRAP_MODE=0) or wrapping past (WRAP_MODE=1) the terminal value.
REQ-017 state  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-018 Prescaler SHALL count 0..TICK_DIVISOR-1 only in RUN; a step occurs in the cycle it equals TICK_DIVISOR-1, and it then returns to 0.
REQ-019 Prescaler SHALL hold its value in PAUSE and SHALL be zeroed by clear, load, entry to DONE and reset.
REQ-020 On a step, digit 0 SHALL change by one; digit i SHALL change only if all lower digits sit at their boundary (up: base-1, down: 0); the full carry/borrow ripple SHALL complete within one edge.
REQ-021 A digit at its boundary SHALL wrap: up base-1 -> 0, down 0 -> base-1.
REQ-022 Terminal value: up = every digit at base-1; down = every digit 0.
REQ-023 WRAP_MODE=0: a step producing the terminal value SHALL pulse tick and terminal together and move RUN -> DONE, with no further steps.
REQ-024 WRAP_MODE=1: a step from the terminal value SHALL wrap all digits, pulse tick and terminal, and stay in RUN.
REQ-025 Transitions: start takes IDLE/PAUSE -> RUN; stop takes RUN -> PAUSE; clear takes any state -> IDLE; load takes IDLE/PAUSE/DONE -> PAUSE; load in RUN is ignored.
REQ-026 WRAP_MODE=0: start SHALL go to DONE without stepping when number already equals the terminal for the current up_down; otherwise it goes to RUN; this rule also applies in DONE.
REQ-027 Same-cycle priority SHALL be clear > load > stop > start > step; start together with stop yields stop.
REQ-028 A loaded digit >= its base SHALL be clamped to base-1.
REQ-029 A change of up_down SHALL take effect at the next step without disturbing the prescaler.
REQ-030 With TICK_DIVISOR=1, a step SHALL occur on every RUN cycle.

Reset
REQ-031 rst low SHALL immediately force number=0, prescaler=0, tick=0, terminal=0, state=IDLE, regardless of the clock.
REQ-032 Reset deassertion SHALL be synchronised to clk; the first start accepted after release behaves as a start from IDLE.

Verification (bench TICK_DIVISOR=4, default bases)
REQ-033 Assert rst low mid-RUN, between edges -> number=0x0000, state=0 and tick=0 without waiting for a clock edge.
REQ-034 Load 0x0959, up, start -> number stays 0x0959 for 3 cycles, then 0x1000 with tick=1 for one cycle.
REQ-035 WRAP_MODE=0, load 0x5958, up, start -> 0x5959 with tick=1 and terminal=1, state=3, number frozen afterwards.
REQ-036 WRAP_MODE=1, clear, down, start -> after 4 cycles number=0x5959, tick=1, terminal=1, state=1.
REQ-037 Load 0x7FAB -> number=0x5959 (clamped), state=2; clear and load in the same cycle -> number=0x0000, state=0.
REQ-038 Run 2 cycles, stop, idle 10 cycles, start -> tick arrives 2 cycles after the restart; start and stop in the same cycle -> state=2.
